// File: rtl/vga_fb_scanout.sv
// Purpose: turns vga timing (x, y, blank, HS, VS) into 12-bit RGB from a 1bpp 160x120 framebuffer, 4x scaled.
// Latency: fixed 2 CLK from x/y/blank/hs_in/vs_in to rgb/hs_out/vs_out.
// Backpressure: wr_ready drops for the whole clear (DEPTH cycles); scanout never stalls.
module vga_fb_scanout #(
   parameter int          FB_W      = 160,
   parameter int          FB_H      = 120,
   parameter int          WPR       = 10,
   parameter int          DEPTH     = 1200,
   parameter logic [11:0] FG_COLOUR = 12'hFFF,
   parameter logic [11:0] BG_COLOUR = 12'h000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [9:0]  x,
   input  logic [9:0]  y,
   input  logic        blank,
   input  logic        hs_in,
   input  logic        vs_in,
   output logic        hs_out,
   output logic        vs_out,
   output logic [11:0] rgb,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [10:0] wr_addr,
   input  logic [15:0] wr_data,
   input  logic        clr_start,
   input  logic [15:0] clr_value,
   output logic        busy
);

   localparam int             AW     = 11;
   localparam logic [7:0]     FB_W8  = 8'(FB_W);
   localparam logic [7:0]     FB_H8  = 8'(FB_H);
   localparam logic [AW-1:0]  DEPTH_A = AW'(DEPTH);
   localparam logic [AW-1:0]  LAST_A  = AW'(DEPTH - 1);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t        state, state_nxt;
   logic [AW-1:0] cnt, cnt_nxt;
   logic [15:0]   fill, fill_nxt;

   // Scanout address generation; the BRAM's own address register is the first pipeline stage
   logic [7:0]    col, row;
   logic          vis_c;
   logic [3:0]    bit_c;
   logic [AW-1:0] rd_addr_c;
   logic          unused_lsbs;

   assign col         = x[9:2];
   assign row         = y[9:2];
   assign vis_c       = ~blank & (col < FB_W8) & (row < FB_H8);
   assign bit_c       = 4'hF - col[3:0];
   // Address is forced to 0 off-screen so the read index always stays inside the array
   assign rd_addr_c   = vis_c ? (AW'(row) * AW'(WPR) + AW'(col[7:4])) : '0;
   assign unused_lsbs = ^{x[1:0], y[1:0]};

   // Framebuffer memory write port, shared by the clear engine and the host
   logic          we;
   logic [AW-1:0] waddr;
   logic [15:0]   wdata;
   logic [15:0]   mem [DEPTH];
   logic [15:0]   rd_word;

   // Clear engine owns the write port while running; out-of-range host writes are dropped
   always_comb begin
      we    = 1'b0;
      waddr = wr_addr;
      wdata = wr_data;
      if (!RST) begin
         if (state == CLEAR) begin
            we    = 1'b1;
            waddr = cnt;
            wdata = fill;
         end else if (wr_valid && wr_ready && (wr_addr < DEPTH_A)) begin
            we = 1'b1;
         end
      end
   end

   // Dual-port RAM: one write, one synchronous read returning pre-write data on collision
   always_ff @(posedge CLK) begin
      if (we) mem[waddr] <= wdata;
      rd_word <= mem[rd_addr_c];
   end

   // Delay visibility, bit select and syncs alongside the RAM read, then form the colour
   logic       s1_vis;
   logic [3:0] s1_bit;
   logic       hs_d, vs_d;

   always_ff @(posedge CLK) begin
      if (RST) begin
         s1_vis <= 1'b0;
         s1_bit <= 4'd0;
         hs_d   <= 1'b1;
         vs_d   <= 1'b1;
         hs_out <= 1'b1;
         vs_out <= 1'b1;
         rgb    <= 12'h000;
      end else begin
         s1_vis <= vis_c;
         s1_bit <= bit_c;
         hs_d   <= hs_in;
         vs_d   <= vs_in;
         hs_out <= hs_d;
         vs_out <= vs_d;
         rgb    <= s1_vis ? (rd_word[s1_bit] ? FG_COLOUR : BG_COLOUR) : 12'h000;
      end
   end

   // Clear FSM state register
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         cnt   <= '0;
         fill  <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         fill  <= fill_nxt;
      end
   end

   // Clear FSM next state: sweep every word once, ignoring further start pulses
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      fill_nxt  = fill;
      case (state)
         IDLE: begin
            if (clr_start) begin
               state_nxt = CLEAR;
               cnt_nxt   = '0;
               fill_nxt  = clr_value;
            end
         end
         CLEAR: begin
            cnt_nxt = cnt + 1'b1;
            if (cnt == LAST_A) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy     = (state == CLEAR);
   assign wr_ready = (state == IDLE);

endmodule
